// File: rtl/ex_stage_if.sv
// Shared bittyCore execute-stage opcode definitions and the decode/EX/MEM
// signal bundle used by ex_stage.
package bitty_defs;
   localparam logic [2:0] EXE_RES_NONE    = 3'd0;
   localparam logic [2:0] EXE_RES_LOGIC   = 3'd1;
   localparam logic [2:0] EXE_RES_SHIFT   = 3'd2;
   localparam logic [2:0] EXE_RES_ARITH   = 3'd3;
   localparam logic [2:0] EXE_RES_COMPARE = 3'd4;
   localparam logic [2:0] EXE_RES_MULDIV  = 3'd5;

   localparam logic [7:0] EXE_NOP    = 8'h00;
   localparam logic [7:0] EXE_AND    = 8'h01;
   localparam logic [7:0] EXE_OR     = 8'h02;
   localparam logic [7:0] EXE_XOR    = 8'h03;
   localparam logic [7:0] EXE_SLL    = 8'h04;
   localparam logic [7:0] EXE_SRL    = 8'h05;
   localparam logic [7:0] EXE_SRA    = 8'h06;
   localparam logic [7:0] EXE_ADD    = 8'h07;
   localparam logic [7:0] EXE_SUB    = 8'h08;
   localparam logic [7:0] EXE_SLT    = 8'h09;
   localparam logic [7:0] EXE_SLTU   = 8'h0A;
   localparam logic [7:0] EXE_MUL    = 8'h10;
   localparam logic [7:0] EXE_MULH   = 8'h11;
   localparam logic [7:0] EXE_MULHSU = 8'h12;
   localparam logic [7:0] EXE_MULHU  = 8'h13;
   localparam logic [7:0] EXE_DIV    = 8'h14;
   localparam logic [7:0] EXE_DIVU   = 8'h15;
   localparam logic [7:0] EXE_REM    = 8'h16;
   localparam logic [7:0] EXE_REMU   = 8'h17;
endpackage

interface ex_stage_if;
   logic [7:0]  aluop_i;
   logic [2:0]  alusel_i;
   logic [31:0] reg1_i;
   logic [31:0] reg2_i;
   logic [4:0]  wd_i;
   logic        wreg_i;
   logic        flush_i;
   logic        ex_wreg_o;
   logic [4:0]  ex_wd_o;
   logic [31:0] ex_wdata_o;
   logic        stall_req_o;
   logic        mem_wreg_o;
   logic [4:0]  mem_wd_o;
   logic [31:0] mem_wdata_o;

   modport slave (
      input  aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, flush_i,
      output ex_wreg_o, ex_wd_o, ex_wdata_o, stall_req_o,
             mem_wreg_o, mem_wd_o, mem_wdata_o
   );

   modport master (
      output aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, flush_i,
      input  ex_wreg_o, ex_wd_o, ex_wdata_o, stall_req_o,
             mem_wreg_o, mem_wd_o, mem_wdata_o
   );
endinterface

// File: rtl/ex_stage.sv
// bittyCore execute stage: single-cycle ALU and multiply, iterative radix-2
// divider that stalls the pipeline, forwarding path and EX/MEM register.
module ex_stage
   import bitty_defs::*;
#(
   parameter int XLEN = 32
) (
   input logic       clk,
   input logic       rst,
   ex_stage_if.slave bus
);

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_BUSY = 2'd1,
      DIV_DONE = 2'd2
   } div_state_e;

   div_state_e          state_r;
   div_state_e          state_nxt_s;
   logic                is_div_s;
   logic                is_signed_div_s;
   logic                div_special_s;
   logic                stall_s;
   logic                bubble_s;
   logic [XLEN-1:0]     dividend_mag_s;
   logic [XLEN-1:0]     divisor_mag_s;
   logic [XLEN-1:0]     dvd_r;
   logic [XLEN-1:0]     dvs_r;
   logic [XLEN-1:0]     quot_r;
   logic [XLEN-1:0]     rem_r;
   logic [5:0]          cnt_r;
   logic                neg_q_r;
   logic                neg_r_r;
   logic                want_rem_r;
   logic [XLEN:0]       partial_s;
   logic [XLEN:0]       diff_s;
   logic [XLEN-1:0]     quot_fix_s;
   logic [XLEN-1:0]     rem_fix_s;
   logic [XLEN-1:0]     div_result_s;
   logic [XLEN-1:0]     alu_result_s;
   logic                mul_sign_a_s;
   logic                mul_sign_b_s;
   logic [2*XLEN-1:0]   mul_a_s;
   logic [2*XLEN-1:0]   mul_b_s;
   logic [2*XLEN-1:0]   prod_s;

   // Classify the incoming operation as a divide and whether it is signed
   always_comb begin
      is_div_s        = 1'b0;
      is_signed_div_s = 1'b0;
      if (bus.alusel_i == EXE_RES_MULDIV) begin
         case (bus.aluop_i)
            EXE_DIV, EXE_REM: begin
               is_div_s        = 1'b1;
               is_signed_div_s = 1'b1;
            end
            EXE_DIVU, EXE_REMU: is_div_s = 1'b1;
            default:            is_div_s = 1'b0;
         endcase
      end else begin
         is_div_s = 1'b0;
      end
   end

   assign dividend_mag_s = (is_signed_div_s && bus.reg1_i[XLEN-1]) ?
                           ({XLEN{1'b0}} - bus.reg1_i) : bus.reg1_i;
   assign divisor_mag_s  = (is_signed_div_s && bus.reg2_i[XLEN-1]) ?
                           ({XLEN{1'b0}} - bus.reg2_i) : bus.reg2_i;
   assign div_special_s  = (bus.reg2_i == {XLEN{1'b0}}) ||
                           (is_signed_div_s &&
                            bus.reg1_i == {1'b1, {(XLEN-1){1'b0}}} &&
                            bus.reg2_i == {XLEN{1'b1}});

   // A restore step only happens when the partial is below the divisor, so it fits XLEN bits
   assign partial_s    = {rem_r, dvd_r[XLEN-1]};
   assign diff_s       = partial_s - {1'b0, dvs_r};
   assign quot_fix_s   = neg_q_r ? ({XLEN{1'b0}} - quot_r) : quot_r;
   assign rem_fix_s    = neg_r_r ? ({XLEN{1'b0}} - rem_r) : rem_r;
   assign div_result_s = want_rem_r ? rem_fix_s : quot_fix_s;

   // Sign-extend to 2*XLEN so one unsigned multiply yields every signedness variant
   assign mul_sign_a_s = bus.reg1_i[XLEN-1] &
                         ((bus.aluop_i == EXE_MULH) || (bus.aluop_i == EXE_MULHSU));
   assign mul_sign_b_s = bus.reg2_i[XLEN-1] & (bus.aluop_i == EXE_MULH);
   assign mul_a_s      = {{XLEN{mul_sign_a_s}}, bus.reg1_i};
   assign mul_b_s      = {{XLEN{mul_sign_b_s}}, bus.reg2_i};
   assign prod_s       = mul_a_s * mul_b_s;

   // Result selection by class and operation
   always_comb begin
      alu_result_s = {XLEN{1'b0}};
      case (bus.alusel_i)
         EXE_RES_LOGIC: begin
            case (bus.aluop_i)
               EXE_AND: alu_result_s = bus.reg1_i & bus.reg2_i;
               EXE_OR:  alu_result_s = bus.reg1_i | bus.reg2_i;
               EXE_XOR: alu_result_s = bus.reg1_i ^ bus.reg2_i;
               default: alu_result_s = {XLEN{1'b0}};
            endcase
         end
         EXE_RES_SHIFT: begin
            case (bus.aluop_i)
               EXE_SLL: alu_result_s = bus.reg1_i << bus.reg2_i[4:0];
               EXE_SRL: alu_result_s = bus.reg1_i >> bus.reg2_i[4:0];
               EXE_SRA: alu_result_s = $signed(bus.reg1_i) >>> bus.reg2_i[4:0];
               default: alu_result_s = {XLEN{1'b0}};
            endcase
         end
         EXE_RES_ARITH: begin
            case (bus.aluop_i)
               EXE_ADD: alu_result_s = bus.reg1_i + bus.reg2_i;
               EXE_SUB: alu_result_s = bus.reg1_i - bus.reg2_i;
               default: alu_result_s = {XLEN{1'b0}};
            endcase
         end
         EXE_RES_COMPARE: begin
            case (bus.aluop_i)
               EXE_SLT:  alu_result_s = {{(XLEN-1){1'b0}},
                                         $signed(bus.reg1_i) < $signed(bus.reg2_i)};
               EXE_SLTU: alu_result_s = {{(XLEN-1){1'b0}}, bus.reg1_i < bus.reg2_i};
               default:  alu_result_s = {XLEN{1'b0}};
            endcase
         end
         EXE_RES_MULDIV: begin
            case (bus.aluop_i)
               EXE_MUL:                        alu_result_s = prod_s[XLEN-1:0];
               EXE_MULH, EXE_MULHSU, EXE_MULHU: alu_result_s = prod_s[2*XLEN-1:XLEN];
               EXE_DIV, EXE_DIVU, EXE_REM, EXE_REMU:
                  alu_result_s = (state_r == DIV_DONE) ? div_result_s : {XLEN{1'b0}};
               default:                        alu_result_s = {XLEN{1'b0}};
            endcase
         end
         default: alu_result_s = {XLEN{1'b0}};
      endcase
   end

   // Divider FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= DIV_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Divider FSM next-state logic
   always_comb begin
      state_nxt_s = DIV_IDLE;
      if (bus.flush_i) begin
         state_nxt_s = DIV_IDLE;
      end else begin
         case (state_r)
            DIV_IDLE: state_nxt_s = !is_div_s ? DIV_IDLE :
                                    (div_special_s ? DIV_DONE : DIV_BUSY);
            DIV_BUSY: state_nxt_s = (cnt_r == 6'd31) ? DIV_DONE : DIV_BUSY;
            DIV_DONE: state_nxt_s = DIV_IDLE;
            default:  state_nxt_s = DIV_IDLE;
         endcase
      end
   end

   // Divider FSM outputs: stall request and the forwarding bundle
   always_comb begin
      stall_s = 1'b0;
      if (bus.flush_i) begin
         stall_s = 1'b0;
      end else begin
         case (state_r)
            DIV_IDLE: stall_s = is_div_s;
            DIV_BUSY: stall_s = 1'b1;
            DIV_DONE: stall_s = 1'b0;
            default:  stall_s = 1'b0;
         endcase
      end
      bubble_s        = stall_s | bus.flush_i;
      bus.stall_req_o = stall_s;
      bus.ex_wreg_o   = bubble_s ? 1'b0 : bus.wreg_i;
      bus.ex_wd_o     = bus.wd_i;
      bus.ex_wdata_o  = alu_result_s;
   end

   // Divider operand capture and one restoring step per BUSY cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         dvd_r      <= {XLEN{1'b0}};
         dvs_r      <= {XLEN{1'b0}};
         quot_r     <= {XLEN{1'b0}};
         rem_r      <= {XLEN{1'b0}};
         cnt_r      <= 6'd0;
         neg_q_r    <= 1'b0;
         neg_r_r    <= 1'b0;
         want_rem_r <= 1'b0;
      end else begin
         case (state_r)
            DIV_IDLE: begin
               if (is_div_s && !bus.flush_i) begin
                  cnt_r      <= 6'd0;
                  want_rem_r <= (bus.aluop_i == EXE_REM) || (bus.aluop_i == EXE_REMU);
                  if (div_special_s) begin
                     neg_q_r <= 1'b0;
                     neg_r_r <= 1'b0;
                     if (bus.reg2_i == {XLEN{1'b0}}) begin
                        quot_r <= {XLEN{1'b1}};
                        rem_r  <= bus.reg1_i;
                     end else begin
                        quot_r <= {1'b1, {(XLEN-1){1'b0}}};
                        rem_r  <= {XLEN{1'b0}};
                     end
                  end else begin
                     dvd_r   <= dividend_mag_s;
                     dvs_r   <= divisor_mag_s;
                     quot_r  <= {XLEN{1'b0}};
                     rem_r   <= {XLEN{1'b0}};
                     neg_q_r <= is_signed_div_s &
                                (bus.reg1_i[XLEN-1] ^ bus.reg2_i[XLEN-1]);
                     neg_r_r <= is_signed_div_s & bus.reg1_i[XLEN-1];
                  end
               end
            end
            DIV_BUSY: begin
               dvd_r  <= {dvd_r[XLEN-2:0], 1'b0};
               rem_r  <= diff_s[XLEN] ? partial_s[XLEN-1:0] : diff_s[XLEN-1:0];
               quot_r <= {quot_r[XLEN-2:0], ~diff_s[XLEN]};
               cnt_r  <= cnt_r + 6'd1;
            end
            default: begin
               cnt_r <= cnt_r;
            end
         endcase
      end
   end

   // EX/MEM pipeline register; stalls and flushes insert a bubble
   always_ff @(posedge clk) begin
      if (rst || bubble_s) begin
         bus.mem_wreg_o  <= 1'b0;
         bus.mem_wd_o    <= 5'd0;
         bus.mem_wdata_o <= {XLEN{1'b0}};
      end else begin
         bus.mem_wreg_o  <= bus.ex_wreg_o;
         bus.mem_wd_o    <= bus.ex_wd_o;
         bus.mem_wdata_o <= bus.ex_wdata_o;
      end
   end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed vector table, randomized ops
// against an arithmetic reference model, and divide stall/flush/reset sequences.
module tb_ex_stage;
   import bitty_defs::*;

   typedef struct {
      logic [2:0]  sel;
      logic [7:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   ex_stage_if bus ();

   ex_stage #(.XLEN(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference result from the ISA rules, written with plain integer arithmetic
   function automatic logic [31:0] model(input logic [2:0] sel, input logic [7:0] op,
                                         input logic [31:0] a, input logic [31:0] b);
      int          sa;
      int          sb;
      logic [63:0] p;
      logic        ovf;
      sa  = a;
      sb  = b;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      model = 32'd0;
      case (sel)
         EXE_RES_LOGIC:
            model = (op == EXE_AND) ? (a & b) : (op == EXE_OR) ? (a | b) :
                    (op == EXE_XOR) ? (a ^ b) : 32'd0;
         EXE_RES_SHIFT:
            model = (op == EXE_SLL) ? (a << b[4:0]) : (op == EXE_SRL) ? (a >> b[4:0]) :
                    (op == EXE_SRA) ? 32'(sa >>> b[4:0]) : 32'd0;
         EXE_RES_ARITH:
            model = (op == EXE_ADD) ? (a + b) : (op == EXE_SUB) ? (a - b) : 32'd0;
         EXE_RES_COMPARE:
            model = (op == EXE_SLT) ? ((sa < sb) ? 32'd1 : 32'd0) :
                    (op == EXE_SLTU) ? ((a < b) ? 32'd1 : 32'd0) : 32'd0;
         EXE_RES_MULDIV: begin
            case (op)
               EXE_MUL:    begin p = 64'(longint'(sa) * longint'(sb)); model = p[31:0]; end
               EXE_MULH:   begin p = 64'(longint'(sa) * longint'(sb)); model = p[63:32]; end
               EXE_MULHSU: begin p = 64'(longint'(sa) * longint'({32'd0, b})); model = p[63:32]; end
               EXE_MULHU:  begin p = {32'd0, a} * {32'd0, b}; model = p[63:32]; end
               EXE_DIV:    model = (b == 32'd0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
               EXE_DIVU:   model = (b == 32'd0) ? 32'hFFFF_FFFF : (a / b);
               EXE_REM:    model = (b == 32'd0) ? a : ovf ? 32'd0 : 32'(sa % sb);
               EXE_REMU:   model = (b == 32'd0) ? a : (a % b);
               default:    model = 32'd0;
            endcase
         end
         default: model = 32'd0;
      endcase
   endfunction

   function automatic int div_stall(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
      logic sgn;
      sgn = (op == EXE_DIV) || (op == EXE_REM);
      if (b == 32'd0 || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
      return 33;
   endfunction

   function automatic logic [31:0] pick_operand();
      logic [31:0] edges [5];
      edges[0] = 32'd0; edges[1] = 32'd1; edges[2] = 32'hFFFF_FFFF;
      edges[3] = 32'h8000_0000; edges[4] = 32'h7FFF_FFFF;
      if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 4)];
      return $urandom;
   endfunction

   task automatic drive_nop();
      bus.alusel_i = EXE_RES_NONE;
      bus.aluop_i  = EXE_NOP;
      bus.reg1_i   = 32'd0;
      bus.reg2_i   = 32'd0;
      bus.wd_i     = 5'd0;
      bus.wreg_i   = 1'b0;
      bus.flush_i  = 1'b0;
   endtask

   task automatic drive_op(input logic [2:0] sel, input logic [7:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] wd);
      bus.alusel_i = sel;
      bus.aluop_i  = op;
      bus.reg1_i   = a;
      bus.reg2_i   = b;
      bus.wd_i     = wd;
      bus.wreg_i   = 1'b1;
      bus.flush_i  = 1'b0;
   endtask

   // Single-cycle op: entered just after a falling edge, leaves at the next one
   task automatic alu_vec(input string name, input logic [2:0] sel, input logic [7:0] op,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp,
                          input logic [4:0] wd);
      drive_op(sel, op, a, b, wd);
      #1;
      check({name, " ex_wdata"}, bus.ex_wdata_o, exp);
      check({name, " ex_wreg"}, {31'd0, bus.ex_wreg_o}, 32'd1);
      check({name, " stall"}, {31'd0, bus.stall_req_o}, 32'd0);
      @(posedge clk); #1;
      check({name, " mem_wdata"}, bus.mem_wdata_o, exp);
      check({name, " mem_wd"}, {27'd0, bus.mem_wd_o}, {27'd0, wd});
      @(negedge clk);
   endtask

   // Divide op: counts stall cycles, checks bubbles, then the DONE-cycle result
   task automatic run_div(input string name, input logic [7:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] wd);
      int          n;
      logic        leak;
      logic [31:0] exp;
      exp  = model(EXE_RES_MULDIV, op, a, b);
      n    = 0;
      leak = 1'b0;
      drive_op(EXE_RES_MULDIV, op, a, b, wd);
      #1;
      while (bus.stall_req_o === 1'b1 && n < 60) begin
         if (bus.ex_wreg_o !== 1'b0) leak = 1'b1;
         @(posedge clk); #1;
         if (bus.mem_wreg_o !== 1'b0) leak = 1'b1;
         @(negedge clk); #1;
         n++;
      end
      check({name, " stall cycles"}, 32'(n), 32'(div_stall(op, a, b)));
      check({name, " no write while stalled"}, {31'd0, leak}, 32'd0);
      check({name, " ex_wdata"}, bus.ex_wdata_o, exp);
      check({name, " ex_wreg"}, {31'd0, bus.ex_wreg_o}, 32'd1);
      @(posedge clk); #1;
      check({name, " mem_wdata"}, bus.mem_wdata_o, exp);
      check({name, " mem_wreg"}, {31'd0, bus.mem_wreg_o}, 32'd1);
      drive_nop();
      @(negedge clk);
   endtask

   initial begin
      vec_t        vecs [18];
      logic [2:0]  rsel [15];
      logic [7:0]  rop  [15];
      logic [7:0]  dops [4];
      logic [31:0] a;
      logic [31:0] b;
      int          k;

      vecs[0]  = '{EXE_RES_ARITH,   EXE_ADD,    32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000};
      vecs[1]  = '{EXE_RES_ARITH,   EXE_SUB,    32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE};
      vecs[2]  = '{EXE_RES_LOGIC,   EXE_AND,    32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};
      vecs[3]  = '{EXE_RES_LOGIC,   EXE_OR,     32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0};
      vecs[4]  = '{EXE_RES_LOGIC,   EXE_XOR,    32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0};
      vecs[5]  = '{EXE_RES_SHIFT,   EXE_SRA,    32'h8000_0000, 32'h0000_0004, 32'hF800_0000};
      vecs[6]  = '{EXE_RES_SHIFT,   EXE_SRL,    32'h8000_0000, 32'h0000_0004, 32'h0800_0000};
      vecs[7]  = '{EXE_RES_SHIFT,   EXE_SLL,    32'h0000_0001, 32'h0000_001F, 32'h8000_0000};
      vecs[8]  = '{EXE_RES_SHIFT,   EXE_SLL,    32'h0000_0001, 32'h0000_0020, 32'h0000_0001};
      vecs[9]  = '{EXE_RES_COMPARE, EXE_SLT,    32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
      vecs[10] = '{EXE_RES_COMPARE, EXE_SLTU,   32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
      vecs[11] = '{EXE_RES_MULDIV,  EXE_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
      vecs[12] = '{EXE_RES_MULDIV,  EXE_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
      vecs[13] = '{EXE_RES_MULDIV,  EXE_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
      vecs[14] = '{EXE_RES_MULDIV,  EXE_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      vecs[15] = '{EXE_RES_NONE,    EXE_ADD,    32'h1234_5678, 32'h1111_1111, 32'h0000_0000};
      vecs[16] = '{EXE_RES_ARITH,   EXE_XOR,    32'h1234_5678, 32'h1111_1111, 32'h0000_0000};
      vecs[17] = '{EXE_RES_MULDIV,  EXE_MULHSU, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0001};

      rsel = '{EXE_RES_LOGIC, EXE_RES_LOGIC, EXE_RES_LOGIC, EXE_RES_SHIFT, EXE_RES_SHIFT,
               EXE_RES_SHIFT, EXE_RES_ARITH, EXE_RES_ARITH, EXE_RES_COMPARE, EXE_RES_COMPARE,
               EXE_RES_MULDIV, EXE_RES_MULDIV, EXE_RES_MULDIV, EXE_RES_MULDIV, EXE_RES_NONE};
      rop  = '{EXE_AND, EXE_OR, EXE_XOR, EXE_SLL, EXE_SRL, EXE_SRA, EXE_ADD, EXE_SUB,
               EXE_SLT, EXE_SLTU, EXE_MUL, EXE_MULH, EXE_MULHSU, EXE_MULHU, EXE_ADD};
      dops = '{EXE_DIV, EXE_DIVU, EXE_REM, EXE_REMU};

      // Reset state
      rst = 1'b1;
      drive_nop();
      repeat (2) @(posedge clk);
      #1;
      check("reset mem_wreg", {31'd0, bus.mem_wreg_o}, 32'd0);
      check("reset mem_wd", {27'd0, bus.mem_wd_o}, 32'd0);
      check("reset mem_wdata", bus.mem_wdata_o, 32'd0);
      check("reset stall", {31'd0, bus.stall_req_o}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i])
         alu_vec($sformatf("vec%0d", i), vecs[i].sel, vecs[i].op, vecs[i].a, vecs[i].b,
                 vecs[i].exp, 5'(i + 1));

      for (int i = 0; i < 200; i++) begin
         k = $urandom_range(0, 14);
         a = pick_operand();
         b = pick_operand();
         alu_vec($sformatf("rnd%0d op%0h a=%h b=%h", i, rop[k], a, b), rsel[k], rop[k], a, b,
                 model(rsel[k], rop[k], a, b), 5'($urandom_range(1, 31)));
      end

      run_div("DIV -7/2", EXE_DIV, 32'hFFFF_FFF9, 32'd2, 5'd3);
      run_div("REM -7/2", EXE_REM, 32'hFFFF_FFF9, 32'd2, 5'd4);
      run_div("DIVU 5/0", EXE_DIVU, 32'd5, 32'd0, 5'd5);
      run_div("REM 5/0", EXE_REM, 32'd5, 32'd0, 5'd6);
      run_div("DIV ovf", EXE_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7);
      run_div("REM ovf", EXE_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8);

      for (int i = 0; i < 12; i++) begin
         k = $urandom_range(0, 3);
         a = ($urandom_range(0, 4) == 0) ? 32'h8000_0000 : pick_operand();
         case ($urandom_range(0, 3))
            0:       b = 32'd0;
            1:       b = 32'hFFFF_FFFF;
            2:       b = 32'($urandom_range(1, 9));
            default: b = $urandom;
         endcase
         run_div($sformatf("rdiv%0d op%0h a=%h b=%h", i, dops[k], a, b), dops[k], a, b,
                 5'($urandom_range(1, 31)));
      end

      // Flush in BUSY cycle 10 abandons the divide
      drive_op(EXE_RES_MULDIV, EXE_DIV, 32'hFFFF_FFF9, 32'd2, 5'd9);
      repeat (10) @(posedge clk);
      @(negedge clk); #1;
      check("pre-flush stall", {31'd0, bus.stall_req_o}, 32'd1);
      bus.flush_i = 1'b1;
      #1;
      check("flush stall", {31'd0, bus.stall_req_o}, 32'd0);
      check("flush ex_wreg", {31'd0, bus.ex_wreg_o}, 32'd0);
      @(posedge clk); #1;
      check("flush mem_wreg", {31'd0, bus.mem_wreg_o}, 32'd0);
      drive_nop();
      @(negedge clk); #1;
      check("post-flush stall", {31'd0, bus.stall_req_o}, 32'd0);
      @(negedge clk);
      run_div("DIVU 100/7 after flush", EXE_DIVU, 32'd100, 32'd7, 5'd10);

      // Reset mid-divide abandons it
      drive_op(EXE_RES_MULDIV, EXE_DIVU, 32'hDEAD_BEEF, 32'd3, 5'd11);
      repeat (15) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      drive_nop();
      @(posedge clk); #1;
      check("rst mid-div mem_wreg", {31'd0, bus.mem_wreg_o}, 32'd0);
      check("rst mid-div mem_wdata", bus.mem_wdata_o, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("post-rst stall", {31'd0, bus.stall_req_o}, 32'd0);
      @(negedge clk);
      run_div("DIVU 100/7 after rst", EXE_DIVU, 32'd100, 32'd7, 5'd12);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
